report_tx_arbiter: RTL

- Shares the single write port of the UART TX FIFO between NUM_REQ report sources: the cache-event counter reporter, debug/trace emitters and future sources.
- Arbitration is per packet, round-robin. Once granted, a source keeps the port until its last byte, so ASCII records ('a'/'b'/'c' tag plus hex digits) never interleave.
- Applies FIFO-full backpressure to the granted source. Releases the port on a stalled source (timeout) or a runaway source (over-length).

---
 rtl/report_tx_pkg.sv | 17 +
 rtl/report_tx_arbiter_rr_pick.sv | 29 ++
 rtl/report_tx_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/report_tx_pkg.sv
// Shared types and constants for the report TX path.
// Used by the arbiter and by every report source.
package report_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;

    // Record tags for the ASCII report stream
    localparam logic [7:0] TAG_A = 8'h61;
    localparam logic [7:0] TAG_B = 8'h62;
    localparam logic [7:0] TAG_C = 8'h63;

endpackage

// File: rtl/report_tx_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after ptr.
// Purely combinational, wraps modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int PW = $clog2(NUM_REQ);

    // Scan from the farthest offset down so the nearest hit wins
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                idx = PW'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/report_tx_arbiter.sv
// Packet round-robin arbiter for the UART TX FIFO write port.
// Holds a grant until last byte, timeout, or over-length.
module report_tx_arbiter
    import report_tx_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_PKT_LEN = 32,
    parameter int TIMEOUT     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [DATA_W-1:0]            fifo_din,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         err_timeout,
    output logic                         err_overlen,
    output logic [15:0]                  pkt_count
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_PKT_LEN + 1);
    localparam int SW = $clog2(TIMEOUT + 1);

    state_t                           state;
    logic [GW-1:0]                    rr_ptr;
    logic [GW-1:0]                    pick_idx;
    logic                             pick_any;
    logic [GW-1:0]                    nxt_ptr;
    logic [BW-1:0]                    byte_cnt;
    logic [SW-1:0]                    stall_cnt;
    logic [NUM_REQ-1:0][DATA_W-1:0]   data_arr;

    logic in_xfer;
    logic g_valid;
    logic g_last;
    logic cap_hit;
    logic to_hit;
    logic ev_done;
    logic ev_cap;
    logic ev_byte;
    logic ev_to;
    logic ev_stall;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign data_arr = req_data;
    assign in_xfer  = (state == XFER);
    assign g_valid  = req_valid[grant_id];
    assign g_last   = req_last[grant_id];

    assign fifo_wr_en = in_xfer & g_valid & ~fifo_full;
    assign fifo_din   = fifo_wr_en ? data_arr[grant_id] : '0;

    assign nxt_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0
                   : grant_id + GW'(1);

    assign cap_hit = (byte_cnt == BW'(MAX_PKT_LEN - 1));
    assign to_hit  = (stall_cnt == SW'(TIMEOUT - 1));

    // Mutually exclusive per-cycle events while transferring
    assign ev_done  = fifo_wr_en & g_last;
    assign ev_cap   = fifo_wr_en & ~g_last & cap_hit;
    assign ev_byte  = fifo_wr_en & ~g_last & ~cap_hit;
    assign ev_to    = ~g_valid & to_hit;
    assign ev_stall = ~g_valid & ~to_hit;

    // Only the owner sees ready, gated by FIFO space
    always_comb begin
        req_ready = '0;
        if (in_xfer) begin
            req_ready[grant_id] = ~fifo_full;
        end
    end

    // Grant / transfer / release control with registered flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_overlen <= 1'b0;
            pkt_count   <= '0;
            byte_cnt    <= '0;
            stall_cnt   <= '0;
        end else begin
            err_timeout <= 1'b0;
            err_overlen <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id  <= pick_idx;
                        busy      <= 1'b1;
                        byte_cnt  <= '0;
                        stall_cnt <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    unique case (1'b1)
                        ev_done: begin
                            pkt_count <= pkt_count + 16'd1;
                            rr_ptr    <= nxt_ptr;
                            busy      <= 1'b0;
                            byte_cnt  <= '0;
                            stall_cnt <= '0;
                            state     <= IDLE;
                        end
                        ev_cap: begin
                            err_overlen <= 1'b1;
                            rr_ptr      <= nxt_ptr;
                            busy        <= 1'b0;
                            byte_cnt    <= '0;
                            stall_cnt   <= '0;
                            state       <= IDLE;
                        end
                        ev_byte: begin
                            byte_cnt  <= byte_cnt + BW'(1);
                            stall_cnt <= '0;
                        end
                        ev_to: begin
                            err_timeout <= 1'b1;
                            rr_ptr      <= nxt_ptr;
                            busy        <= 1'b0;
                            byte_cnt    <= '0;
                            stall_cnt   <= '0;
                            state       <= IDLE;
                        end
                        ev_stall: begin
                            stall_cnt <= stall_cnt + SW'(1);
                        end
                        default: begin
                            // FIFO full with data pending: hold counters
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
